// File: rtl/pipeline_hazard_ctrl_if.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
//   Bundle between the hazard controller and the five-stage pipeline.
//   master : hazard controller (samples hazard inputs, drives stall/clear,
//            pc_load and the performance counters)
//   slave  : pipeline side (drives hazard inputs, consumes control)
//
//   IF_memaccess / imem_resp    : imem request outstanding / completes now
//   MEM_memaccess / dmem_resp   : dmem request outstanding / completes now
//   ID_rs1, ID_rs2, ID_uses_rs* : source operands of the ID instruction
//   EX_rd, EX_is_load           : destination / load flag of EX instruction
//   EX_br_taken                 : EX resolved a taken branch or jump
//   pc_load                     : PC register load enable
//   stall_<buf> / clear_<buf>   : hold / bubble for IF_ID, ID_EX, EX_MEM, MEM_WB
//   stall_count / flush_count   : saturating performance counters
// ----------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 IF_memaccess;
  logic                 imem_resp;
  logic                 MEM_memaccess;
  logic                 dmem_resp;
  logic [4:0]           ID_rs1;
  logic [4:0]           ID_rs2;
  logic                 ID_uses_rs1;
  logic                 ID_uses_rs2;
  logic [4:0]           EX_rd;
  logic                 EX_is_load;
  logic                 EX_br_taken;

  logic                 pc_load;
  logic                 stall_IF_ID;
  logic                 stall_ID_EX;
  logic                 stall_EX_MEM;
  logic                 stall_MEM_WB;
  logic                 clear_IF_ID;
  logic                 clear_ID_EX;
  logic                 clear_EX_MEM;
  logic                 clear_MEM_WB;
  logic [CNT_WIDTH-1:0] stall_count;
  logic [CNT_WIDTH-1:0] flush_count;

  modport master (
    input  IF_memaccess, imem_resp, MEM_memaccess, dmem_resp,
           ID_rs1, ID_rs2, ID_uses_rs1, ID_uses_rs2,
           EX_rd, EX_is_load, EX_br_taken,
    output pc_load,
           stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB,
           clear_IF_ID, clear_ID_EX, clear_EX_MEM, clear_MEM_WB,
           stall_count, flush_count
  );

  modport slave (
    output IF_memaccess, imem_resp, MEM_memaccess, dmem_resp,
           ID_rs1, ID_rs2, ID_uses_rs1, ID_uses_rs2,
           EX_rd, EX_is_load, EX_br_taken,
    input  pc_load,
           stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB,
           clear_IF_ID, clear_ID_EX, clear_EX_MEM, clear_MEM_WB,
           stall_count, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Stall/clear generator for the four pipeline buffers plus the PC load
//   enable. Handles imem/dmem wait states, EX-resolved redirects, load-use
//   hazards and discarding a fetch that belongs to a squashed path. Keeps
//   saturating stall-cycle and redirect counters.
//
//   clk    : clock, all state updates on the rising edge
//   reset  : synchronous, active-high
//   hz     : pipeline_hazard_ctrl_if.master (hazard inputs in, control out)
//
//   All control outputs are combinational from the one-bit FSM state and
//   the current inputs; decisions take effect in the same cycle.
// ----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  pipeline_hazard_ctrl_if.master hz
);

  // RUN     : normal operation
  // DISCARD : an imem fetch from the squashed path is still outstanding
  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_DISCARD = 1'b1
  } state_e;

  // Buffer index order inside the vectors: [3]=IF_ID [2]=ID_EX [1]=EX_MEM [0]=MEM_WB
  typedef struct packed {
    logic       pc_load;
    logic [3:0] stall;
    logic [3:0] clear;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE  = '{pc_load: 1'b1, stall: 4'b0000, clear: 4'b0000};
  localparam ctrl_t CTRL_RESET = '{pc_load: 1'b0, stall: 4'b0000, clear: 4'b1111};
  localparam ctrl_t CTRL_DMEM  = '{pc_load: 1'b0, stall: 4'b1111, clear: 4'b0000};
  localparam ctrl_t CTRL_REDIR = '{pc_load: 1'b1, stall: 4'b0000, clear: 4'b1100};
  localparam ctrl_t CTRL_LUH   = '{pc_load: 1'b0, stall: 4'b1000, clear: 4'b0100};
  localparam ctrl_t CTRL_IBUB  = '{pc_load: 1'b0, stall: 4'b0000, clear: 4'b1000};

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  ctrl_t ctrl;
  logic  flush_inc;

  // --------------------------------------------------------------------------
  // Hazard terms
  // --------------------------------------------------------------------------
  logic dstall, istall, rs1_hit, rs2_hit, luh;

  assign dstall  = hz.MEM_memaccess & ~hz.dmem_resp;
  assign istall  = hz.IF_memaccess  & ~hz.imem_resp;
  assign rs1_hit = hz.ID_uses_rs1 & (hz.ID_rs1 == hz.EX_rd);
  assign rs2_hit = hz.ID_uses_rs2 & (hz.ID_rs2 == hz.EX_rd);
  // x0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign luh     = hz.EX_is_load & (hz.EX_rd != 5'd0) & (rs1_hit | rs2_hit);

  // --------------------------------------------------------------------------
  // Next-state and control decode
  // --------------------------------------------------------------------------
  // NOTE: every signal written here gets a default before any branch, so no
  // path leaves a value unassigned and no latch can be inferred.
  always_comb begin
    ctrl      = CTRL_IDLE;
    state_d   = state_q;
    flush_inc = 1'b0;

    if (reset) begin
      ctrl    = CTRL_RESET;
      state_d = ST_RUN;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (dstall) begin
            // Whole pipe frozen; a pending redirect or load-use stays on the
            // EX/ID inputs and is acted on once dmem completes.
            ctrl = CTRL_DMEM;
          end else if (hz.EX_br_taken) begin
            ctrl      = CTRL_REDIR;
            flush_inc = 1'b1;
            // The in-flight fetch is for the wrong path; its response must
            // be thrown away when it finally arrives.
            if (istall) state_d = ST_DISCARD;
          end else if (luh) begin
            ctrl = CTRL_LUH;
          end else if (istall) begin
            ctrl = CTRL_IBUB;
          end
        end

        ST_DISCARD: begin
          // Only bubbles are upstream, so redirect and load-use are ignored.
          ctrl = dstall ? CTRL_DMEM : CTRL_IBUB;
          // The squashed fetch completes with this response; the PC already
          // holds the redirect target and IF re-requests it next cycle.
          if (hz.imem_resp) state_d = ST_RUN;
        end

        default: begin
          ctrl    = CTRL_RESET;
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Saturating performance counters
  // --------------------------------------------------------------------------
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!ctrl.pc_load && stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_ONE;
    if (flush_inc && flush_cnt_q != CNT_MAX)     flush_cnt_d = flush_cnt_q + CNT_ONE;
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign hz.pc_load      = ctrl.pc_load;
  assign hz.stall_IF_ID  = ctrl.stall[3];
  assign hz.stall_ID_EX  = ctrl.stall[2];
  assign hz.stall_EX_MEM = ctrl.stall[1];
  assign hz.stall_MEM_WB = ctrl.stall[0];
  assign hz.clear_IF_ID  = ctrl.clear[3];
  assign hz.clear_ID_EX  = ctrl.clear[2];
  assign hz.clear_EX_MEM = ctrl.clear[1];
  assign hz.clear_MEM_WB = ctrl.clear[0];
  assign hz.stall_count  = stall_cnt_q;
  assign hz.flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//   Two instances share one stimulus: a 32-bit-counter instance and a
//   4-bit-counter instance used to reach saturation quickly. Outputs are
//   compared every cycle against a rule-level reference model; a vector
//   table and hand sequences pin down the corner cases with constants.
// ----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  typedef struct packed {
    logic       ifm;
    logic       iresp;
    logic       mm;
    logic       dresp;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       ld;
    logic       br;
  } in_t;

  typedef struct {
    in_t        stim;
    logic [8:0] exp_o;
    string      name;
  } vec_t;

  // Output vector: {pc_load, stall IF_ID,ID_EX,EX_MEM,MEM_WB, clear IF_ID,ID_EX,EX_MEM,MEM_WB}
  localparam logic [8:0] O_IDLE  = 9'h100;
  localparam logic [8:0] O_RESET = 9'h00F;
  localparam logic [8:0] O_DMEM  = 9'h0F0;
  localparam logic [8:0] O_REDIR = 9'h10C;
  localparam logic [8:0] O_LUH   = 9'h084;
  localparam logic [8:0] O_IBUB  = 9'h008;

  logic clk;
  logic reset;

  pipeline_hazard_ctrl_if #(.CNT_WIDTH(32)) hz  ();
  pipeline_hazard_ctrl_if #(.CNT_WIDTH(4))  hz4 ();

  pipeline_hazard_ctrl #(.CNT_WIDTH(32)) dut  (.clk(clk), .reset(reset), .hz(hz.master));
  pipeline_hazard_ctrl #(.CNT_WIDTH(4))  dut4 (.clk(clk), .reset(reset), .hz(hz4.master));

  assign hz4.IF_memaccess  = hz.IF_memaccess;
  assign hz4.imem_resp     = hz.imem_resp;
  assign hz4.MEM_memaccess = hz.MEM_memaccess;
  assign hz4.dmem_resp     = hz.dmem_resp;
  assign hz4.ID_rs1        = hz.ID_rs1;
  assign hz4.ID_rs2        = hz.ID_rs2;
  assign hz4.ID_uses_rs1   = hz.ID_uses_rs1;
  assign hz4.ID_uses_rs2   = hz.ID_uses_rs2;
  assign hz4.EX_rd         = hz.EX_rd;
  assign hz4.EX_is_load    = hz.EX_is_load;
  assign hz4.EX_br_taken   = hz.EX_br_taken;

  wire [8:0] outs = {hz.pc_load,
                     hz.stall_IF_ID, hz.stall_ID_EX, hz.stall_EX_MEM, hz.stall_MEM_WB,
                     hz.clear_IF_ID, hz.clear_ID_EX, hz.clear_EX_MEM, hz.clear_MEM_WB};
  wire [8:0] outs4 = {hz4.pc_load,
                      hz4.stall_IF_ID, hz4.stall_ID_EX, hz4.stall_EX_MEM, hz4.stall_MEM_WB,
                      hz4.clear_IF_ID, hz4.clear_ID_EX, hz4.clear_EX_MEM, hz4.clear_MEM_WB};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: squashed fetch pending, plus unbounded counts.
  bit     m_disc = 1'b0;
  longint m_sc   = 0;
  longint m_fc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic in_t mk(input logic ifm, input logic iresp, input logic mm, input logic dresp,
                             input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic u1, input logic u2,
                             input logic [4:0] rd, input logic ld, input logic br);
    in_t v;
    v.ifm = ifm; v.iresp = iresp; v.mm = mm; v.dresp = dresp;
    v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
    v.rd = rd; v.ld = ld; v.br = br;
    return v;
  endfunction

  function automatic logic [31:0] sat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? 32'(mx) : 32'(v);
  endfunction

  // Expected control from the priority rules.
  function automatic logic [8:0] model_out(input in_t v, input logic rst, input bit disc);
    bit d_st, i_st, dep;
    d_st = v.mm && !v.dresp;
    i_st = v.ifm && !v.iresp;
    dep  = v.ld && (v.rd != 0) && ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
    if (rst)       return O_RESET;
    if (d_st)      return O_DMEM;
    if (disc)      return O_IBUB;
    if (v.br)      return O_REDIR;
    if (dep)       return O_LUH;
    if (i_st)      return O_IBUB;
    return O_IDLE;
  endfunction

  task automatic drive(input logic rst, input in_t v);
    reset            = rst;
    hz.IF_memaccess  = v.ifm;
    hz.imem_resp     = v.iresp;
    hz.MEM_memaccess = v.mm;
    hz.dmem_resp     = v.dresp;
    hz.ID_rs1        = v.rs1;
    hz.ID_rs2        = v.rs2;
    hz.ID_uses_rs1   = v.u1;
    hz.ID_uses_rs2   = v.u2;
    hz.EX_rd         = v.rd;
    hz.EX_is_load    = v.ld;
    hz.EX_br_taken   = v.br;
  endtask

  // One clock: drive after the falling edge, compare, then advance the model
  // to what the following rising edge must produce.
  task automatic cycle(input logic rst, input in_t v);
    logic [8:0] e;
    @(negedge clk);
    drive(rst, v);
    #1;
    e = model_out(v, rst, m_disc);
    check("ctrl", 32'(outs), 32'(e));
    check("ctrl_w4", 32'(outs4), 32'(e));
    check("stall_count", hz.stall_count, sat(m_sc, 32));
    check("flush_count", hz.flush_count, sat(m_fc, 32));
    check("stall_count_w4", 32'(hz4.stall_count), sat(m_sc, 4));
    check("flush_count_w4", 32'(hz4.flush_count), sat(m_fc, 4));
    if (rst) begin
      m_disc = 1'b0;
      m_sc   = 0;
      m_fc   = 0;
    end else begin
      if (!e[8]) m_sc++;
      if (m_disc) begin
        if (v.iresp) m_disc = 1'b0;
      end else if (e == O_REDIR) begin
        m_fc++;
        if (v.ifm && !v.iresp) m_disc = 1'b1;
      end
    end
  endtask

  in_t idle_v;

  task automatic do_reset();
    cycle(1'b1, idle_v);
    cycle(1'b1, idle_v);
  endtask

  vec_t tbl[12];

  initial begin
    idle_v = mk(0,0,0,0, 5'd0,5'd0, 0,0, 5'd0, 0,0);
    drive(1'b1, idle_v);

    tbl[0]  = '{stim: mk(0,0,0,0, 5'd1,5'd2, 0,0, 5'd3, 0,0), exp_o: O_IDLE,  name: "idle"};
    tbl[1]  = '{stim: mk(0,0,1,0, 5'd1,5'd2, 0,0, 5'd3, 0,0), exp_o: O_DMEM,  name: "dmiss"};
    tbl[2]  = '{stim: mk(0,0,1,1, 5'd1,5'd2, 0,0, 5'd3, 0,0), exp_o: O_IDLE,  name: "dhit"};
    tbl[3]  = '{stim: mk(0,0,0,0, 5'd1,5'd2, 0,0, 5'd3, 0,1), exp_o: O_REDIR, name: "redir"};
    tbl[4]  = '{stim: mk(0,0,0,0, 5'd1,5'd7, 0,1, 5'd7, 1,0), exp_o: O_LUH,   name: "luh_rs2"};
    tbl[5]  = '{stim: mk(0,0,0,0, 5'd7,5'd7, 0,0, 5'd7, 1,0), exp_o: O_IDLE,  name: "load_unused"};
    tbl[6]  = '{stim: mk(0,0,0,0, 5'd7,5'd7, 1,1, 5'd7, 0,0), exp_o: O_IDLE,  name: "match_noload"};
    tbl[7]  = '{stim: mk(1,0,0,0, 5'd1,5'd2, 0,0, 5'd3, 0,0), exp_o: O_IBUB,  name: "imiss"};
    tbl[8]  = '{stim: mk(1,0,0,0, 5'd9,5'd2, 1,0, 5'd9, 1,0), exp_o: O_LUH,   name: "luh_over_imiss"};
    tbl[9]  = '{stim: mk(0,0,1,0, 5'd9,5'd2, 1,0, 5'd9, 1,1), exp_o: O_DMEM,  name: "dmiss_over_all"};
    tbl[10] = '{stim: mk(1,1,0,0, 5'd1,5'd2, 0,0, 5'd3, 0,0), exp_o: O_IDLE,  name: "ihit"};
    tbl[11] = '{stim: mk(0,0,0,0, 5'd0,5'd0, 1,1, 5'd0, 1,0), exp_o: O_IDLE,  name: "luh_x0"};

    // T1: reset state and release
    do_reset();
    check("t1_reset_ctrl", 32'(outs), 32'(O_RESET));
    check("t1_reset_sc", hz.stall_count, 32'd0);
    cycle(1'b0, idle_v);
    check("t1_release_ctrl", 32'(outs), 32'(O_IDLE));

    // Vector table (all in RUN)
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, tbl[i].stim);
      check(tbl[i].name, 32'(outs), 32'(tbl[i].exp_o));
    end

    // T2: load-use, then same with EX_rd=0
    do_reset();
    cycle(1'b0, mk(0,0,0,0, 5'd5,5'd0, 1,0, 5'd5, 1,0));
    check("t2_luh", 32'(outs), 32'(O_LUH));
    cycle(1'b0, mk(0,0,0,0, 5'd0,5'd0, 1,0, 5'd0, 1,0));
    check("t2_rd0", 32'(outs), 32'(O_IDLE));
    check("t2_stall_count", hz.stall_count, 32'd1);

    // T3: dmem miss 3 cycles with a pending redirect
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, mk(0,0,1,0, 5'd0,5'd0, 0,0, 5'd0, 0,1));
      check("t3_frozen", 32'(outs), 32'(O_DMEM));
    end
    cycle(1'b0, mk(0,0,1,1, 5'd0,5'd0, 0,0, 5'd0, 0,1));
    check("t3_redirect", 32'(outs), 32'(O_REDIR));
    cycle(1'b0, idle_v);
    check("t3_flush_count", hz.flush_count, 32'd1);
    check("t3_stall_count", hz.stall_count, 32'd3);

    // T4: redirect with imem outstanding -> DISCARD until the stale response
    do_reset();
    cycle(1'b0, mk(1,0,0,0, 5'd0,5'd0, 0,0, 5'd0, 0,1));
    check("t4_redirect", 32'(outs), 32'(O_REDIR));
    for (int i = 0; i < 2; i++) begin
      // Branch and load-use present but must be ignored while discarding.
      cycle(1'b0, mk(1,0,0,0, 5'd4,5'd0, 1,0, 5'd4, 1,1));
      check("t4_discard", 32'(outs), 32'(O_IBUB));
    end
    cycle(1'b0, mk(1,1,0,0, 5'd0,5'd0, 0,0, 5'd0, 0,0));
    check("t4_drop_resp", 32'(outs), 32'(O_IBUB));
    cycle(1'b0, idle_v);
    check("t4_back_to_run", 32'(outs), 32'(O_IDLE));
    check("t4_flush_count", hz.flush_count, 32'd1);

    // T5: saturation of the 4-bit counter
    do_reset();
    for (int i = 0; i < 20; i++) cycle(1'b0, mk(0,0,0,0, 5'd6,5'd0, 1,0, 5'd6, 1,0));
    cycle(1'b0, idle_v);
    check("t5_sat_w4", 32'(hz4.stall_count), 32'd15);
    check("t5_count_w32", hz.stall_count, 32'd20);

    // T6: reset during DISCARD
    do_reset();
    cycle(1'b0, mk(1,0,0,0, 5'd0,5'd0, 0,0, 5'd0, 0,1));
    cycle(1'b0, mk(1,0,0,0, 5'd0,5'd0, 0,0, 5'd0, 0,0));
    check("t6_in_discard", 32'(outs), 32'(O_IBUB));
    cycle(1'b1, mk(1,0,0,0, 5'd0,5'd0, 0,0, 5'd0, 0,0));
    check("t6_reset_ctrl", 32'(outs), 32'(O_RESET));
    cycle(1'b0, idle_v);
    check("t6_run_after", 32'(outs), 32'(O_IDLE));
    check("t6_counters", {hz.stall_count[15:0], hz.flush_count[15:0]}, 32'd0);

    // Randomised traffic against the reference model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      in_t v;
      logic r;
      r       = ($urandom_range(0, 99) == 0);
      v.ifm   = 1'($urandom_range(0, 1));
      v.iresp = ($urandom_range(0, 2) == 0);
      v.mm    = ($urandom_range(0, 3) == 0);
      v.dresp = 1'($urandom_range(0, 1));
      v.rs1   = 5'($urandom_range(0, 3));
      v.rs2   = 5'($urandom_range(0, 3));
      v.u1    = 1'($urandom_range(0, 1));
      v.u2    = 1'($urandom_range(0, 1));
      v.rd    = 5'($urandom_range(0, 3));
      v.ld    = 1'($urandom_range(0, 1));
      v.br    = ($urandom_range(0, 4) == 0);
      cycle(r, v);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
